bcd_conv_scheduler: RTL and testbench
=====================================

// Module: bcd_conv_scheduler
// PURPOSE
//  Time-shares one combinational binary-to-BCD converter among N_REQ requesters.
//  Example requesters: dispensed volume, preset volume and price.
//  Each requester gets its own 6-digit BCD result register, which feeds the HEX display mux.
//  Sits between the pump-control/measurement logic and the 7-segment display path.
//  Grants are round-robin. Conversions are multi-cycle, so the deep adder chain of
//  the shared converter is given SETTLE_CYC clocks.
// PARAMETERS
//  N_REQ      3   number of requesters (2..8)
//  BIN_W      16  binary operand width (ml / units)
//  DIGITS     6   BCD digits per result (6*4 = 24 bits)
//  SETTLE_CYC 2   clocks conv_bcd is allowed to settle after conv_bin is loaded (>=1)
// PORTS
//  clk         in   1              system clock, rising edge
//  rst         in   1              asynchronous, active-high reset
//  req         in   N_REQ          level request; hold with value until ack
//  value_flat  in   N_REQ*BIN_W    operand for requester k at [k*BIN_W +: BIN_W]
//  ack         out  N_REQ          one-cycle pulse: result for k written this cycle
//  conv_bin    out  BIN_W          registered operand to the shared converter
//  conv_bcd    in   DIGITS*4       converter output (nibble 0 = units)
//  result_flat out  N_REQ*DIGITS*4 per-requester BCD result, held until next conversion
//  result_vld  out  N_REQ          1 once requester k has at least one result
//  busy        out  1              1 in S_WAIT / S_DONE
//  conv_err    out  1              sticky: a captured nibble was >9
// BEHAVIOUR
//  Reset: every output and register is 0. Includes state=S_IDLE, rr_ptr=0 and all results.
//  Reset is asynchronous. Asserting it mid-conversion aborts the conversion with no ack
//  and clears result_vld.
//  FSM states and transitions:
//   S_IDLE: if |req, pick g = first set req at or after rr_ptr, wrapping modulo N_REQ.
//           On the edge: conv_bin<=value[g], gnt<=g, cnt<=SETTLE_CYC-1, go to S_WAIT.
//   S_WAIT: cnt!=0 -> cnt--. cnt==0 -> go to S_DONE.
//   S_DONE: result[gnt]<=conv_bcd, result_vld[gnt]<=1, ack[gnt]=1 for this cycle only.
//           rr_ptr<=(gnt+1)%N_REQ, then go to S_IDLE.
//  Latency: req seen in S_IDLE at cycle 0 -> ack high in cycle SETTLE_CYC+1 (3 by default).
//  Throughput: one conversion per SETTLE_CYC+2 cycles. S_IDLE always lasts >=1 cycle.
//  Operand handling: captured at grant. Changes to value or req after grant are ignored.
//  If req drops during a conversion, the conversion still completes and ack still pulses.
//  Requester re-arm: a requester holding req after its ack is re-granted only after the
//  others have had their turn (round-robin fairness). No requester starves.
//  Simultaneous requests: exactly one grant per S_IDLE visit. ack is one-hot or zero.
//  Result capture: result_flat changes only in S_DONE and only in the granted slot.
//  Other slots hold their values.
//  conv_err: set in S_DONE if any captured nibble is >9. Cleared only by rst.
//  Width: BIN_W=16 gives a maximum of 65535. This needs 5 digits, so digit 5 is always 0.
// STRUCTURE
//  Shared header fuel_disp_defs.vh defines:
//   - BIN_W, DIGITS and BCD_W = DIGITS*4
//   - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_DONE=2'd2
//  Shared by this block, the display mux and the measurement logic.
//  Sub-module rr_arbiter (N_REQ): combinational next-grant index from req and rr_ptr.
//  The existing binary-to-BCD converter is instantiated outside this block, at top level.
// TESTING
//  Bench instantiates the real converter on conv_bin/conv_bcd.
//  1 Single request: req=001, value0=1234 -> ack=001 in cycle 3. Result slot 0 = 24'h001234.
//    result_vld=001.
//  2 Boundaries, one at a time on req[1]:
//    - value1=0 -> 24'h000000
//    - value1=65535 -> 24'h065535
//    - value1=9999 -> 24'h009999
//    conv_err stays 0 throughout.
//  3 Contention: req=111 held, values 10/20/30 -> acks in order 001,010,100,001,...
//    Each ack is 4 cycles apart. Results are 24'h000010/000020/000030.
//  4 Operand change and req drop: change value0 from 500 to 700 during S_WAIT, then drop req0.
//    -> Result 24'h000500 with one ack pulse. Next request returns 24'h000700.
//  5 Reset mid-conversion: rst during S_WAIT -> no ack, all outputs 0.
//    After release, req=010 with value 42 -> result slot 1 = 24'h000042.
//  6 Error injection: force conv_bcd nibble to 4'hA -> conv_err=1 after S_DONE.
//    It stays 1 until rst.

Source files
------------

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared definitions for the BCD conversion scheduler: default sizes,
// FSM state encoding and a small nibble-check helper.
package bcd_conv_scheduler_pkg;

    localparam int DEF_N_REQ      = 3;
    localparam int DEF_BIN_W      = 16;
    localparam int DEF_DIGITS     = 6;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_BCD_W      = DEF_DIGITS * 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A BCD nibble above 9 means the converter produced garbage.
    function automatic logic nibble_bad(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin grant selection: returns the first active
// request at or after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int               slot;
    logic [IDX_W-1:0] slot_idx;

    // Scan from farthest to nearest so the slot closest to rr_ptr wins last.
    always_comb begin
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            slot     = (int'(rr_ptr) + i) % N_REQ;
            slot_idx = IDX_W'(slot);
            if (req[slot_idx]) begin
                gnt_idx = slot_idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one external binary-to-BCD converter among N_REQ requesters,
// granting round-robin and giving the converter SETTLE_CYC clocks per job.
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int BIN_W      = DEF_BIN_W,
    parameter int DIGITS     = DEF_DIGITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*BIN_W-1:0]      value_flat,
    output logic [N_REQ-1:0]            ack,
    output logic [BIN_W-1:0]            conv_bin,
    input  logic [DIGITS*4-1:0]         conv_bcd,
    output logic [N_REQ*DIGITS*4-1:0]   result_flat,
    output logic [N_REQ-1:0]            result_vld,
    output logic                        busy,
    output logic                        conv_err
);

    localparam int BCD_W = DIGITS * 4;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t                       state;
    state_t                       state_next;
    logic [IDX_W-1:0]             gnt;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             arb_idx;
    logic                         arb_any;
    logic [CNT_W-1:0]             cnt;
    logic                         load;
    logic                         capture;
    logic                         bcd_bad;
    logic [N_REQ-1:0][BCD_W-1:0]  result_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Next-state logic: one grant per idle visit, fixed settle time, one capture cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_any) begin
                    load       = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                capture    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Acknowledge only the granted requester, and only during the capture cycle.
    always_comb begin
        ack = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (capture && (gnt == IDX_W'(k))) begin
                ack[k] = 1'b1;
            end
        end
    end

    // Flag any converter digit that is not a legal BCD value.
    always_comb begin
        bcd_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (nibble_bad(conv_bcd[d*4 +: 4])) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the operand and grant at grant time, then count down the settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_bin <= '0;
            gnt      <= '0;
            cnt      <= '0;
        end else if (load) begin
            conv_bin <= value_flat[int'(arb_idx)*BIN_W +: BIN_W];
            gnt      <= arb_idx;
            cnt      <= CNT_INIT;
        end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture the settled result into the granted slot and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            result_vld <= '0;
            conv_err   <= 1'b0;
            rr_ptr     <= '0;
        end else if (capture) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt == IDX_W'(k)) begin
                    result_q[k]   <= conv_bcd;
                    result_vld[k] <= 1'b1;
                end
            end
            rr_ptr <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
            if (bcd_bad) begin
                conv_err <= 1'b1;
            end
        end
    end

    assign result_flat = result_q;
    assign busy        = (state == S_WAIT) || (state == S_DONE);

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler: stimulus predicts grant order,
// timing and BCD results; a monitor checks each ack as it appears.
module tb_bcd_conv_scheduler;

    localparam int N_REQ   = 3;
    localparam int BIN_W   = 16;
    localparam int DIGITS  = 6;
    localparam int BCD_W   = DIGITS * 4;
    localparam int TIMEOUT = 200;

    typedef struct {
        int               slot;
        logic [BCD_W-1:0] bcd;
        int               cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [N_REQ-1:0]          req = '0;
    logic [N_REQ*BIN_W-1:0]    value_flat;
    logic [N_REQ-1:0]          ack;
    logic [BIN_W-1:0]          conv_bin;
    logic [BCD_W-1:0]          conv_bcd;
    logic [N_REQ*BCD_W-1:0]    result_flat;
    logic [N_REQ-1:0]          result_vld;
    logic                      busy;
    logic                      conv_err;

    logic                      inject_err = 1'b0;
    logic [BIN_W-1:0]          val [N_REQ];
    int                        cyc = 0;
    int                        n_checks = 0;
    int                        n_fails = 0;
    exp_t                      sb [$];
    logic [BCD_W-1:0]          exp_result [N_REQ];
    logic [N_REQ-1:0]          exp_vld = '0;
    logic                      exp_err = 1'b0;
    int                        model_ptr = 0;

    bcd_conv_scheduler #(
        .N_REQ      (N_REQ),
        .BIN_W      (BIN_W),
        .DIGITS     (DIGITS),
        .SETTLE_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .value_flat  (value_flat),
        .ack         (ack),
        .conv_bin    (conv_bin),
        .conv_bcd    (conv_bcd),
        .result_flat (result_flat),
        .result_vld  (result_vld),
        .busy        (busy),
        .conv_err    (conv_err)
    );

    // Decimal digits by repeated division.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // What the converter will show for an operand, including the fault injection.
    function automatic logic [BCD_W-1:0] exp_bcd(input logic [BIN_W-1:0] v, input logic inj);
        logic [BCD_W-1:0] r;
        r = to_bcd(32'(v));
        if (inj) r[3:0] = 4'hA;
        return r;
    endfunction

    // First set request at or after ptr, wrapping.
    function automatic int next_grant(input logic [N_REQ-1:0] mask, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (mask[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    // Clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the shared converter.
    always_comb begin
        conv_bcd = to_bcd(32'(conv_bin));
        if (inject_err) conv_bcd[3:0] = 4'hA;
    end

    // Pack the per-requester operands.
    always_comb begin
        value_flat = '0;
        for (int k = 0; k < N_REQ; k++) value_flat[k*BIN_W +: BIN_W] = val[k];
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic resetModel();
        sb.delete();
        for (int k = 0; k < N_REQ; k++) exp_result[k] = '0;
        exp_vld   = '0;
        exp_err   = 1'b0;
        model_ptr = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"}, ack, 0);
        checkOutput({tag, "_conv_bin"}, conv_bin, 0);
        checkOutput({tag, "_result_flat"}, result_flat, 0);
        checkOutput({tag, "_result_vld"}, result_vld, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_conv_err"}, conv_err, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        checkAllZero("reset");
        resetModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        @(negedge clk);
        while (busy && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL wait_idle: busy stuck at 1, expected 0");
        end
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((sb.size() != 0 || busy) && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL drain: %0d acks outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // held=0: each requester drops req on its ack. held>0: mask held for 'held' acks.
    task automatic applyStimulus(input logic [N_REQ-1:0] mask, input int held);
        int               total;
        int               seen;
        int               waited;
        int               s;
        int               c0;
        logic [N_REQ-1:0] remaining;
        waitIdle();
        c0        = cyc;
        remaining = mask;
        total     = (held > 0) ? held : $countones(mask);
        for (int n = 0; n < total; n++) begin
            s = next_grant((held > 0) ? mask : remaining, model_ptr);
            sb.push_back('{s, exp_bcd(val[s], inject_err), c0 + 3 + 4 * n});
            model_ptr = (s + 1) % N_REQ;
            remaining[s] = 1'b0;
        end
        req    = mask;
        seen   = 0;
        waited = 0;
        while (seen < total && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
            if (ack != '0) seen++;
            if (held == 0) req = req & ~ack;
        end
        req = '0;
        if (seen < total) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL ack_timeout: saw %0d acks, expected %0d", seen, total);
        end
    endtask

    // Monitor: every ack must match the next expected conversion.
    initial begin
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                exp_t                   e;
                logic [N_REQ*BCD_W-1:0] flat;
                checkOutput("ack_onehot", ($countones(ack) == 1), 1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_ack: ack=%b, expected none", ack);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_slot", ack, 128'(1) << e.slot);
                    checkOutput("ack_cycle", cyc, e.cyc);
                    exp_result[e.slot] = e.bcd;
                    exp_vld[e.slot]    = 1'b1;
                    for (int d = 0; d < DIGITS; d++) begin
                        if (e.bcd[d*4 +: 4] > 4'd9) exp_err = 1'b1;
                    end
                    flat = '0;
                    for (int k = 0; k < N_REQ; k++) flat[k*BCD_W +: BCD_W] = exp_result[k];
                    @(posedge clk);
                    #1;
                    checkOutput("result_flat", result_flat, flat);
                    checkOutput("result_vld", result_vld, exp_vld);
                    checkOutput("conv_err", conv_err, exp_err);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [BIN_W-1:0] bounds [4];
        bounds[0] = 16'd0;
        bounds[1] = 16'd65535;
        bounds[2] = 16'd9999;
        bounds[3] = 16'd10000;
        for (int k = 0; k < N_REQ; k++) val[k] = '0;
        resetModel();

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        checkAllZero("por");
        rst = 1'b0;

        $display("[TB] single request");
        val[0] = 16'd1234;
        applyStimulus(3'b001, 0);
        waitDrain();

        $display("[TB] boundaries on requester 1");
        for (int b = 0; b < 3; b++) begin
            val[1] = bounds[b];
            applyStimulus(3'b010, 0);
            waitDrain();
        end

        $display("[TB] contention");
        doReset();
        val[0] = 16'd10;
        val[1] = 16'd20;
        val[2] = 16'd30;
        applyStimulus(3'b111, 7);
        waitDrain();

        $display("[TB] operand change and req drop");
        waitIdle();
        val[0] = 16'd500;
        req    = 3'b001;
        sb.push_back('{0, to_bcd(500), cyc + 3});
        model_ptr = 1;
        @(negedge clk);
        checkOutput("busy_in_wait", busy, 1);
        val[0] = 16'd700;
        @(negedge clk);
        req = '0;
        waitDrain();
        applyStimulus(3'b001, 0);
        waitDrain();

        $display("[TB] reset mid-conversion");
        waitIdle();
        val[0] = 16'd999;
        req    = 3'b001;
        @(negedge clk);
        checkOutput("busy_before_abort", busy, 1);
        rst = 1'b1;
        req = '0;
        #1;
        checkAllZero("abort");
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        val[1] = 16'd42;
        applyStimulus(3'b010, 0);
        waitDrain();

        $display("[TB] error injection");
        inject_err = 1'b1;
        val[2] = 16'd77;
        applyStimulus(3'b100, 0);
        waitDrain();
        inject_err = 1'b0;
        val[2] = 16'd88;
        applyStimulus(3'b100, 0);
        waitDrain();
        checkOutput("conv_err_sticky", conv_err, 1);
        doReset();

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(0, 3) == 0) val[k] = bounds[$urandom_range(0, 3)];
                else val[k] = BIN_W'($urandom_range(0, 65535));
            end
            if ($urandom_range(0, 3) == 0)
                applyStimulus(N_REQ'($urandom_range(1, 7)), $urandom_range(1, 5));
            else
                applyStimulus(N_REQ'($urandom_range(1, 7)), 0);
            waitDrain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
